// File: rtl/alu_pkg.sv
// Shared definitions for the serial add/subtract unit: FSM states, flag
// bit positions and operation mode encodings.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_N = 3;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage : alu_pkg

// File: rtl/digit_addsub_slice.sv
// Combinational W-bit ripple adder / direct-borrow subtractor slice.
// msb_cin is the carry/borrow entering the top bit, used for overflow.
module digit_addsub_slice
  import alu_pkg::*;
#(
  parameter int unsigned W = 1
) (
  input  logic [W-1:0] a_slice,
  input  logic [W-1:0] b_slice,
  input  logic         mode,
  input  logic         cin,
  output logic [W-1:0] sum_slice,
  output logic         cout,
  output logic         msb_cin
);

  always_comb begin
    logic c;
    c         = cin;
    sum_slice = '0;
    msb_cin   = 1'b0;
    for (int unsigned i = 0; i < W; i++) begin
      if (i == W - 1) begin
        msb_cin = c;
      end
      sum_slice[i] = a_slice[i] ^ b_slice[i] ^ c;
      if (mode == MODE_SUB) begin
        c = (~a_slice[i] & b_slice[i]) | (~(a_slice[i] ^ b_slice[i]) & c);
      end else begin
        c = (a_slice[i] & b_slice[i]) | ((a_slice[i] ^ b_slice[i]) & c);
      end
    end
    cout = c;
  end

endmodule : digit_addsub_slice

// File: rtl/serial_addsub_unit.sv
// Multi-cycle add/subtract unit: W bits per clock, LSB first, with
// registered result and NZCV flags held between operations.
module serial_addsub_unit
  import alu_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         mode,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic [3:0]   flags
);

  localparam int unsigned SLICES = N / W;
  localparam int unsigned CNT_W  = (SLICES > 1) ? $clog2(SLICES) : 1;

  if (N < 2 || W < 1 || W > N || (N % W) != 0) begin : g_bad_params
    $error("serial_addsub_unit: N must be >= 2 and a multiple of W");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N-1:0]       a_q, a_d;
  logic [N-1:0]       b_q, b_d;
  logic               mode_q, mode_d;
  logic               carry_q, carry_d;
  logic [N-1:0]       acc_q, acc_d;
  logic [N-1:0]       result_q, result_d;
  logic [3:0]         flags_q, flags_d;

  logic [W-1:0]       sum_slice;
  logic               slice_cout;
  logic               slice_msb_cin;
  logic [N-1:0]       acc_shift;
  logic               last_slice;

  digit_addsub_slice #(
    .W (W)
  ) u_slice (
    .a_slice   (a_q[W-1:0]),
    .b_slice   (b_q[W-1:0]),
    .mode      (mode_q),
    .cin       (carry_q),
    .sum_slice (sum_slice),
    .cout      (slice_cout),
    .msb_cin   (slice_msb_cin)
  );

  // New slice enters at the top so the first (LSB) slice ends up at bit 0.
  assign acc_shift  = (acc_q >> W) | (N'(sum_slice) << (N - W));
  assign last_slice = (cnt_q == CNT_W'(SLICES - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    mode_d   = mode_q;
    carry_d  = carry_q;
    acc_d    = acc_q;
    result_d = result_q;
    flags_d  = flags_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          mode_d  = mode;
          cnt_d   = '0;
          carry_d = 1'b0;
          acc_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d   = acc_shift;
        a_d     = a_q >> W;
        b_d     = b_q >> W;
        carry_d = slice_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_slice) begin
          // Overflow taken from the carry chain: carry into MSB xor carry out.
          result_d         = acc_shift;
          flags_d[FLAG_Z]  = ~|acc_shift;
          flags_d[FLAG_N]  = acc_shift[N-1];
          flags_d[FLAG_C]  = slice_cout;
          flags_d[FLAG_V]  = slice_cout ^ slice_msb_cin;
          cnt_d            = '0;
          state_d          = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= 1'b0;
      carry_q  <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mode_q   <= mode_d;
      carry_q  <= carry_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign busy   = (state_q == BUSY);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign flags  = flags_q;

endmodule : serial_addsub_unit

// File: tb/tb_serial_addsub_unit.sv
// Directed self-checking bench for serial_addsub_unit with N=8, W=2.
module tb_serial_addsub_unit;

  logic       clk;
  logic       rst;
  logic       start;
  logic       mode;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic [3:0] flags;

  int checks;
  int errors;
  logic [7:0] exp_res;
  int done_cnt;

  serial_addsub_unit #(
    .N (8),
    .W (2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mode   (mode),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .flags  (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Runs one operation and checks busy/done timing, hold of the old result, and final result/flags.
  task automatic do_op(input string tag, input logic m, input logic [7:0] xa, input logic [7:0] xb,
                       input logic [7:0] er, input logic [3:0] ef);
    @(negedge clk);
    start = 1'b1; mode = m; a = xa; b = xb;
    @(negedge clk);
    start = 1'b0; mode = ~m; a = ~xa; b = ~xb;
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) @(negedge clk);
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_nodone"}, 32'(done), 32'd0);
      chk({tag, "_hold"}, 32'(result), 32'(exp_res));
    end
    @(negedge clk);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy_off"}, 32'(busy), 32'd0);
    chk({tag, "_result"}, 32'(result), 32'(er));
    chk({tag, "_flags"}, 32'(flags), 32'(ef));
    exp_res = er;
    @(negedge clk);
    chk({tag, "_done_off"}, 32'(done), 32'd0);
    chk({tag, "_idle_result"}, 32'(result), 32'(er));
    chk({tag, "_idle_flags"}, 32'(flags), 32'(ef));
  endtask

  initial begin
    checks = 0; errors = 0; exp_res = 8'h00;
    rst = 1'b1; start = 1'b0; mode = 1'b0; a = 8'h00; b = 8'h00;
    #2;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", 32'(result), 32'h00);
    chk("reset_flags", 32'(flags), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    do_op("sub_zero", 1'b1, 8'h05, 8'h05, 8'h00, 4'b0001);
    do_op("sub_borrow", 1'b1, 8'h03, 8'h05, 8'hFE, 4'b1100);
    do_op("add_ovf", 1'b0, 8'h7F, 8'h01, 8'h80, 4'b1010);
    do_op("add_carry", 1'b0, 8'hFF, 8'h01, 8'h00, 4'b0101);

    // Start pulsed mid-BUSY must be ignored and not queued.
    @(negedge clk);
    start = 1'b1; mode = 1'b1; a = 8'h80; b = 8'h01;
    done_cnt = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b1; mode = 1'b0; a = 8'h55; b = 8'h22;
      end else begin
        start = 1'b0;
      end
      if (done) done_cnt++;
      chk("ign_busy", 32'(busy), (k >= 1 && k <= 4) ? 32'd1 : 32'd0);
      chk("ign_done", 32'(done), (k == 5) ? 32'd1 : 32'd0);
      if (k >= 5) begin
        chk("ign_result", 32'(result), 32'h7F);
        chk("ign_flags", 32'(flags), 32'h2);
      end
    end
    chk("ign_done_count", 32'(done_cnt), 32'd1);
    exp_res = 8'h7F;

    do_op("add_plain", 1'b0, 8'h10, 8'h20, 8'h30, 4'b0000);

    // Reset during the second BUSY cycle discards the operation.
    @(negedge clk);
    start = 1'b1; mode = 1'b1; a = 8'hFF; b = 8'h01;
    @(negedge clk);
    start = 1'b0;
    chk("rst_mid_busy1", 32'(busy), 32'd1);
    @(negedge clk);
    chk("rst_mid_busy2", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_result", 32'(result), 32'h00);
    chk("rst_mid_flags", 32'(flags), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    exp_res = 8'h00;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk("rst_no_done", 32'(done), 32'd0);
      chk("rst_no_busy", 32'(busy), 32'd0);
    end

    do_op("sub_after_rst", 1'b1, 8'h0A, 8'h03, 8'h07, 4'b0000);

    // Start held high: one operation every 6 cycles.
    @(negedge clk);
    start = 1'b1; mode = 1'b0; a = 8'h11; b = 8'h22;
    done_cnt = 0;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 18) start = 1'b0;
      if (done) done_cnt++;
      chk("b2b_busy", 32'(busy), ((k % 6) >= 1 && (k % 6) <= 4) ? 32'd1 : 32'd0);
      chk("b2b_done", 32'(done), ((k % 6) == 5) ? 32'd1 : 32'd0);
      chk("b2b_result", 32'(result), (k < 5) ? 32'h07 : 32'h33);
    end
    chk("b2b_done_count", 32'(done_cnt), 32'd3);
    chk("b2b_flags", 32'(flags), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_serial_addsub_unit
